// File: rtl/ifu_fetch_ctrl.sv
// ifu_fetch_ctrl: drives a one-cycle-latency instruction SRAM and hands fetched instructions to decode via valid/ready
module ifu_fetch_ctrl #(
  parameter logic [31:0] RESET_PC = 32'h8000_0000
) (
  input  logic        clk_i,
  input  logic        rst_i,
  output logic        imem_ren_o,
  output logic [31:0] imem_addr_o,
  input  logic [31:0] imem_rdata_i,
  output logic        if_valid_o,
  input  logic        if_ready_i,
  output logic [31:0] if_pc_o,
  output logic [31:0] if_inst_o,
  input  logic        redirect_valid_i,
  input  logic [31:0] redirect_pc_i,
  input  logic        halt_i,
  output logic        fault_o,
  output logic [31:0] fault_pc_o
);
  typedef enum logic [1:0] {IDLE, RUN, HALT, FAULT} state_t;
  state_t state_q, state_d;
  logic [31:0] pc_q, pc_d, rsp_pc_q, rsp_pc_d, fault_pc_q, fault_pc_d;
  logic rsp_valid_q, rsp_valid_d, fault_q, fault_d;
  logic xfer, misalign, issue;
  assign if_valid_o = rsp_valid_q && !redirect_valid_i;
  assign xfer = if_valid_o && if_ready_i;
  assign misalign = redirect_valid_i && |redirect_pc_i[1:0];
  assign issue = redirect_valid_i || !rsp_valid_q || if_ready_i;
  assign if_pc_o = rsp_pc_q;
  assign if_inst_o = imem_rdata_i;
  assign fault_o = fault_q;
  assign fault_pc_o = fault_pc_q;
  always_comb begin
    state_d = state_q;
    pc_d = pc_q;
    rsp_valid_d = rsp_valid_q;
    rsp_pc_d = rsp_pc_q;
    fault_d = fault_q;
    fault_pc_d = fault_pc_q;
    imem_ren_o = 1'b0;
    imem_addr_o = pc_q;
    case (state_q)
      IDLE: state_d = RUN;
      RUN: begin
        if (misalign) begin
          state_d = FAULT;
          fault_d = 1'b1;
          fault_pc_d = redirect_pc_i;
          rsp_valid_d = 1'b0;
        end else if (halt_i) begin
          state_d = HALT;
          rsp_valid_d = rsp_valid_q && !xfer;
        end else begin
          imem_addr_o = redirect_valid_i ? redirect_pc_i : pc_q;
          imem_ren_o = issue;
          if (issue) begin
            pc_d = imem_addr_o + 32'd4;
            rsp_pc_d = imem_addr_o;
            rsp_valid_d = 1'b1;
          end
        end
      end
      HALT: rsp_valid_d = rsp_valid_q && !xfer;
      default: rsp_valid_d = 1'b0;
    endcase
  end
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= IDLE;
      pc_q <= RESET_PC;
      rsp_valid_q <= 1'b0;
      rsp_pc_q <= '0;
      fault_q <= 1'b0;
      fault_pc_q <= '0;
    end else begin
      state_q <= state_d;
      pc_q <= pc_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_pc_q <= rsp_pc_d;
      fault_q <= fault_d;
      fault_pc_q <= fault_pc_d;
    end
  end
endmodule

// File: tb/tb_ifu_fetch_ctrl.sv
// tb_ifu_fetch_ctrl: directed scoreboard bench for ifu_fetch_ctrl with a behavioural SRAM
module tb_ifu_fetch_ctrl;
  logic clk = 1'b0;
  logic rst, rdy, rv, halt;
  logic [31:0] rpc;
  logic ren, valid, fault;
  logic [31:0] addr, rdata, pc, inst, fpc;
  int n_cmp = 0;
  int n_err = 0;
  logic [31:0] sb[$];
  ifu_fetch_ctrl dut (
    .clk_i(clk), .rst_i(rst), .imem_ren_o(ren), .imem_addr_o(addr), .imem_rdata_i(rdata),
    .if_valid_o(valid), .if_ready_i(rdy), .if_pc_o(pc), .if_inst_o(inst),
    .redirect_valid_i(rv), .redirect_pc_i(rpc), .halt_i(halt), .fault_o(fault), .fault_pc_o(fpc)
  );
  always #5 clk = ~clk;
  function automatic logic [31:0] img(input logic [31:0] a);
    return ~a ^ 32'h0BAD_F00D;
  endfunction
  always_ff @(posedge clk) if (ren) rdata <= img(addr);
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask
  task automatic step(input logic r, input logic y, input logic v, input logic [31:0] p, input logic h);
    @(posedge clk);
    #1;
    rst = r; rdy = y; rv = v; rpc = p; halt = h;
    @(negedge clk);
  endtask
  always @(negedge clk) begin
    if (valid && rdy) begin
      if (sb.size() == 0) begin
        n_cmp++;
        n_err++;
        $error("FAIL sb_unexpected: observed pc %h expected no transfer", pc);
      end else begin
        logic [31:0] e;
        e = sb.pop_front();
        chk("sb_pc", pc, e);
        chk("sb_inst", inst, img(e));
      end
    end
  end
  initial begin
    rst = 1; rdy = 1; rv = 0; rpc = 0; halt = 0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_valid", valid, 0); chk("rst_ren", ren, 0); chk("rst_fault", fault, 0); chk("rst_pc", pc, 0);
    step(0, 1, 0, 0, 0);
    chk("idle_ren", ren, 0);
    sb.push_back(32'h8000_0000);
    step(0, 1, 0, 0, 0);
    chk("first_ren", ren, 1); chk("first_addr", addr, 32'h8000_0000); chk("first_valid", valid, 0);
    sb.push_back(32'h8000_0004);
    step(0, 1, 0, 0, 0);
    chk("run_addr1", addr, 32'h8000_0004); chk("run_pc0", pc, 32'h8000_0000);
    for (int i = 0; i < 3; i++) begin
      step(0, 0, 0, 0, 0);
      chk("bp_ren", ren, 0); chk("bp_valid", valid, 1);
      chk("bp_pc", pc, 32'h8000_0004); chk("bp_inst", inst, img(32'h8000_0004));
    end
    sb.push_back(32'h8000_0008);
    step(0, 1, 0, 0, 0);
    chk("rel_ren", ren, 1); chk("rel_addr", addr, 32'h8000_0008);
    step(0, 1, 0, 0, 0);
    chk("run_pc8", pc, 32'h8000_0008); chk("run_addrc", addr, 32'h8000_000C);
    step(0, 0, 0, 0, 0);
    chk("stall_ren", ren, 0); chk("stall_pc", pc, 32'h8000_000C);
    sb.push_back(32'h8000_0100);
    sb.push_back(32'h8000_0104);
    step(0, 0, 1, 32'h8000_0100, 0);
    chk("redir_valid", valid, 0); chk("redir_ren", ren, 1); chk("redir_addr", addr, 32'h8000_0100);
    step(0, 1, 0, 0, 0);
    chk("tgt_pc", pc, 32'h8000_0100); chk("tgt_addr", addr, 32'h8000_0104);
    sb.push_back(32'h8000_0108);
    step(0, 1, 0, 0, 0);
    chk("tgt_pc4", pc, 32'h8000_0104); chk("tgt_addr8", addr, 32'h8000_0108);
    step(0, 0, 0, 0, 1);
    chk("halt_ren", ren, 0); chk("halt_valid", valid, 1); chk("halt_pc", pc, 32'h8000_0108);
    step(0, 0, 0, 0, 0);
    chk("halted_ren", ren, 0); chk("halted_valid", valid, 1);
    step(0, 1, 0, 0, 0);
    chk("drain_ren", ren, 0); chk("drain_valid", valid, 1);
    step(0, 1, 1, 32'h8000_0200, 0);
    chk("halt_redir_ren", ren, 0); chk("halt_redir_valid", valid, 0);
    step(0, 1, 0, 0, 0);
    chk("halt_post_ren", ren, 0); chk("halt_post_valid", valid, 0);
    step(1, 1, 0, 0, 0);
    step(0, 1, 0, 0, 0);
    chk("rst2_ren", ren, 0); chk("rst2_valid", valid, 0); chk("rst2_pc", pc, 0);
    sb.push_back(32'h8000_0000);
    step(0, 1, 0, 0, 0);
    chk("rst2_ren1", ren, 1); chk("rst2_addr", addr, 32'h8000_0000);
    step(0, 1, 0, 0, 0);
    chk("rst2_addr4", addr, 32'h8000_0004);
    step(0, 1, 1, 32'h8000_0102, 0);
    chk("mis_ren", ren, 0); chk("mis_valid", valid, 0);
    step(0, 1, 0, 0, 0);
    chk("fault", fault, 1); chk("fault_pc", fpc, 32'h8000_0102); chk("fault_ren", ren, 0); chk("fault_valid", valid, 0);
    step(0, 1, 1, 32'h8000_0200, 1);
    chk("fault_ign_ren", ren, 0); chk("fault_ign_valid", valid, 0); chk("fault_sticky", fault, 1);
    step(0, 1, 0, 0, 0);
    chk("fault_hold_ren", ren, 0); chk("fault_hold_valid", valid, 0);
    step(1, 1, 0, 0, 0);
    step(0, 1, 0, 0, 0);
    chk("rst3_fault", fault, 0); chk("rst3_fpc", fpc, 0); chk("rst3_ren", ren, 0);
    sb.push_back(32'h8000_0000);
    step(0, 1, 0, 0, 0);
    chk("rst3_ren1", ren, 1); chk("rst3_addr", addr, 32'h8000_0000);
    step(0, 1, 0, 0, 0);
    chk("rst3_addr4", addr, 32'h8000_0004);
    sb.push_back(32'hFFFF_FFFC);
    sb.push_back(32'h0000_0000);
    step(0, 1, 1, 32'hFFFF_FFFC, 0);
    chk("wrap_valid", valid, 0); chk("wrap_ren", ren, 1); chk("wrap_addr", addr, 32'hFFFF_FFFC);
    step(0, 1, 0, 0, 0);
    chk("wrap_pc", pc, 32'hFFFF_FFFC); chk("wrap_next", addr, 32'h0000_0000); chk("wrap_next_ren", ren, 1);
    sb.push_back(32'h0000_0004);
    step(0, 1, 0, 0, 0);
    chk("wrap_pc0", pc, 32'h0000_0000); chk("wrap_addr4", addr, 32'h0000_0004);
    step(1, 1, 0, 0, 0);
    chk("mid_valid", valid, 1); chk("mid_pc", pc, 32'h0000_0004);
    step(0, 1, 0, 0, 0);
    chk("mid_rst_valid", valid, 0); chk("mid_rst_pc", pc, 0);
    chk("sb_empty", sb.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
